// File: rtl/pulse_sequencer.sv
// pulse_sequencer: plays a list of level/duration symbols from an internal memory onto uo_out
module pulse_sequencer #(
    parameter int NUM_WORDS     = 8,
    parameter int CARRIER_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int SYM = 4 * NUM_WORDS;
    localparam int IW  = $clog2(SYM);
    localparam int CW  = CARRIER_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [23:0]             ctrl_q, ctrl_d;
    logic [CW-1:0]           car_q, car_d, cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d, nxt_idx, load_idx;
    logic [6:0]              dur_q, dur_d;
    logic [15:0]             pre_q, pre_d, pre_max;
    logic                    prev_q, done_q, done_d, looped_q, looped_d;
    logic                    ph_q, ph_d, env_q, env_d, pulse_q, pulse_d;
    logic [32*NUM_WORDS-1:0] mem_q;
    logic [7:0]              sym;
    logic                    wr, wr_ctrl, wr_car, wr_stat, tick, last, go, abort;
    logic                    unused_ok;

    assign wr       = data_write_n == 2'b10;
    assign wr_ctrl  = wr && address == 6'h00;
    assign wr_car   = wr && address == 6'h04;
    assign wr_stat  = wr && address == 6'h08;
    assign ctrl_d   = wr_ctrl ? data_in[23:0] : ctrl_q;
    assign car_d    = wr_car ? data_in[CW-1:0] : car_q;
    assign pre_max  = (16'd1 << ctrl_q[23:20]) - 16'd1;
    assign tick     = pre_q == pre_max;
    assign last     = idx_q == ctrl_q[13 +: IW];
    // a CTRL write clearing start takes effect on its own edge so it beats a same-edge completion
    assign abort    = !ctrl_d[0];
    assign go       = state_q == IDLE && ctrl_q[0] && !prev_q;
    assign nxt_idx  = last ? ctrl_q[6 +: IW] : idx_q + 1'b1;
    assign load_idx = go ? ctrl_q[6 +: IW] : nxt_idx;
    assign sym      = mem_q[{load_idx, 3'b000} +: 8];

    assign uo_out         = {4'b0, state_q == RUN, env_q, pulse_q, 1'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = (done_q & ctrl_q[4]) | (looped_q & ctrl_q[5]);
    assign unused_ok      = ^{ui_in, data_read_n};

    // combinational register readback
    always_comb begin
        data_out = '0;
        if (address == 6'h00) data_out[23:0] = ctrl_q;
        if (address == 6'h04) data_out[CW-1:0] = car_q;
        if (address == 6'h08) data_out[IW+2:0] = {idx_q, looped_q, done_q, state_q == RUN};
        for (int w = 0; w < NUM_WORDS; w++)
            if (address == 6'(32 + 4 * w)) data_out = mem_q[32 * w +: 32];
    end

    // symbol memory, word-write only, deliberately not reset
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WORDS; w++)
            if (wr && address == 6'(32 + 4 * w)) mem_q[32 * w +: 32] <= data_in;
    end

    // sequencer next state: abort, start, then tick-driven countdown and advance
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dur_d    = dur_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        env_d    = env_q;
        done_d   = done_q & !(wr_stat && data_in[1]);
        looped_d = looped_q & !(wr_stat && data_in[2]);
        if (abort) begin
            state_d = IDLE;
            env_d   = 1'b0;
            ph_d    = 1'b0;
        end else if (go) begin
            state_d = RUN;
            idx_d   = load_idx;
            dur_d   = sym[6:0];
            env_d   = sym[7];
            pre_d   = '0;
            ph_d    = 1'b0;
            cnt_d   = car_q;
        end else if (state_q == RUN) begin
            pre_d = tick ? '0 : pre_q + 16'd1;
            cnt_d = cnt_q == '0 ? car_q : cnt_q - 1'b1;
            ph_d  = ph_q ^ (cnt_q == '0);
            if (tick && dur_q != '0) begin
                dur_d = dur_q - 1'b1;
            end else if (tick && last && !ctrl_q[1]) begin
                state_d = IDLE;
                env_d   = 1'b0;
                ph_d    = 1'b0;
                done_d  = 1'b1;
            end else if (tick) begin
                idx_d    = nxt_idx;
                dur_d    = sym[6:0];
                env_d    = sym[7];
                looped_d = looped_d | last;
            end
        end
        pulse_d = (env_d & (ctrl_d[2] ? ph_d : 1'b1)) ^ ctrl_d[3];
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            car_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            dur_q    <= '0;
            pre_q    <= '0;
            prev_q   <= 1'b0;
            done_q   <= 1'b0;
            looped_q <= 1'b0;
            ph_q     <= 1'b0;
            env_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            car_q    <= car_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dur_q    <= dur_d;
            pre_q    <= pre_d;
            prev_q   <= ctrl_q[0];
            done_q   <= done_d;
            looped_q <= looped_d;
            ph_q     <= ph_d;
            env_q    <= env_d;
            pulse_q  <= pulse_d;
        end
    end
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: scoreboard bench comparing uo_out/irq against a waveform model built from symbol lists
module tb_pulse_sequencer;
    localparam int SYM = 32;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] m;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h0;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h0;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    ent_t        sb[$];
    ent_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem_m[SYM];
    logic        m_done, m_looped, m_aborted;
    int          m_idx;

    pulse_sequencer #(.NUM_WORDS(8), .CARRIER_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    // monitor: one expected entry per clock, sampled just after the rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.m != 4'h0) begin
                n_vec++;
                if ((({user_interrupt, uo_out[3:1]} ^ mon_e.v) & mon_e.m) != 4'h0 || (uo_out & 8'hf1) != 8'h0) begin
                    n_err++;
                    $display("FAIL uo @%0t: irq,busy,env,pulse=%b uo=%h want %b", $time,
                             {user_interrupt, uo_out[3:1]}, uo_out, mon_e.v);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void push(input logic [3:0] v, input logic [3:0] m);
        ent_t e;
        e.v = v;
        e.m = m;
        sb.push_back(e);
    endfunction

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic wr_word(input int w, input logic [31:0] d);
        for (int b = 0; b < 4; b++) mem_m[4 * w + b] = d[8 * b +: 8];
        wr(6'(32 + 4 * w), d);
    endtask

    task automatic chk(input string nm, input logic [5:0] a, input logic [31:0] m, input logic [31:0] exp);
        address = a;
        #1;
        n_vec++;
        if ((data_out & m) != (exp & m)) begin
            n_err++;
            $display("FAIL %s: data_out=%h want %h (mask %h)", nm, data_out, exp, m);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
            sb.delete();
        end
    endtask

    // program, predict the waveform from the symbol list, start, issue mid-run writes, check status
    task automatic run(input int st, input int en, input int lp, input int p, input int inv, input int cen,
                       input int c, input int ide, input int ile, input int abort_at, input int clear_at,
                       input int tail);
        logic [31:0] cfg;
        logic [7:0]  s;
        logic        ph, pl, wrap, fin;
        int          i, t, idx, len, cur;
        cfg = {8'h0, 4'(p), 7'(en), 7'(st), 1'(ile), 1'(ide), 1'(inv), 1'(cen), 1'(lp), 1'b0};
        drain();
        wr(6'h04, 32'(c));
        wr(6'h08, 32'h6);
        wr(6'h00, cfg);
        m_done = 1'b0;
        m_looped = 1'b0;
        m_aborted = 1'b0;
        push(4'h0, 4'h0);
        i = 1;
        t = 0;
        idx = st;
        wrap = 1'b0;
        fin = 1'b0;
        while (!fin) begin
            s = mem_m[idx];
            len = (int'(s[6:0]) + 1) << p;
            for (int k = 0; k < len && !fin; k++) begin
                if (abort_at != 0 && i >= abort_at) begin
                    fin = 1'b1;
                    m_aborted = 1'b1;
                end else begin
                    m_looped = (wrap && k == 0) || (m_looped && i != clear_at);
                    ph = ((t / (c + 1)) % 2) == 1;
                    pl = (s[7] & (cen != 0 ? ph : 1'b1)) ^ (inv != 0);
                    push({(m_looped && ile != 0), 1'b1, s[7], pl}, 4'hf);
                    i++;
                    t++;
                end
            end
            if (!fin) begin
                if (idx == en && lp != 0) begin
                    idx = st;
                    wrap = 1'b1;
                end else if (idx == en) begin
                    fin = 1'b1;
                    if (abort_at == i) m_aborted = 1'b1;
                    else m_done = 1'b1;
                end else begin
                    idx = (idx + 1) % SYM;
                    wrap = 1'b0;
                end
            end
        end
        m_idx = idx;
        for (int k = 0; k < tail; k++) begin
            m_looped = m_looped && i != clear_at;
            push({(m_done && ide != 0) || (m_looped && ile != 0), 1'b0, 1'b0, 1'(inv)}, 4'hf);
            i++;
        end
        wr(6'h00, cfg | 32'h1);
        cur = 1;
        if (clear_at != 0) begin
            repeat (clear_at - cur) @(negedge clk);
            wr(6'h08, 32'h4);
            cur = clear_at + 1;
        end
        if (abort_at != 0) begin
            repeat (abort_at - cur) @(negedge clk);
            wr(6'h00, cfg);
        end
        drain();
        chk("status", 6'h08, m_aborted ? 32'h7 : 32'hff, 32'({5'(m_idx), m_looped, m_done, 1'b0}));
    endtask

    initial begin
        int st, ln, lp, ab, cl;
        #1;
        chk("reset_data_out", 6'h00, 32'hffffffff, 32'h0);
        n_vec++;
        if (uo_out !== 8'h0 || user_interrupt !== 1'b0 || data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: uo=%h irq=%b rdy=%b want 00 0 1", uo_out, user_interrupt, data_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wr(6'h04, 32'h1234);
        chk("carrier_rb", 6'h04, 32'hffffffff, 32'h1234);
        address = 6'h04;
        data_in = 32'hffff;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
        chk("byte_write_ignored", 6'h04, 32'hffffffff, 32'h1234);
        chk("unmapped", 6'h10, 32'hffffffff, 32'h0);

        for (int w = 0; w < 8; w++) wr_word(w, $urandom & 32'h8f8f8f8f);
        chk("word3_rb", 6'h2c, 32'hffffffff, {mem_m[15], mem_m[14], mem_m[13], mem_m[12]});

        wr_word(0, 32'h00810284);
        run(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        run(0, 2, 0, 2, 1, 0, 0, 1, 0, 0, 0, 3);
        run(1, 2, 1, 0, 0, 0, 0, 0, 1, 40, 12, 3);
        wr_word(1, 32'h00000087);
        run(4, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
        run(0, 2, 0, 0, 0, 0, 0, 1, 0, 3, 0, 3);
        run(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        wr_word(7, 32'h83000000);
        run(31, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3);

        for (int n = 0; n < 12; n++) begin
            st = $urandom_range(0, SYM - 1);
            ln = $urandom_range(1, 5);
            lp = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (lp != 0) begin
                ab = $urandom_range(20, 120);
                cl = $urandom_range(2, ab - 1);
            end else begin
                ab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : 0;
                cl = 0;
            end
            run(st, (st + ln - 1) % SYM, lp, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1), ab, cl, 3);
        end

        drain();
        wr(6'h00, 32'h00004069);
        wr(6'h00, 32'h0000406b);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (uo_out !== 8'h0 || user_interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: uo=%h irq=%b want 00 0", uo_out, user_interrupt);
        end
        chk("async_reset_ctrl", 6'h00, 32'hffffffff, 32'h0);
        chk("async_reset_status", 6'h08, 32'hffffffff, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
